// File: rtl/latency_ram.sv
// Word-addressed RAM with a configurable wait-state count, reporting progress on ramstate.
// Optional macro LATENCY_RAM_ALIGN_CHECK_EN turns misaligned requests into ERROR.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module latency_ram #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramstore,
  output logic [1:0]  ramstate,
  output logic [31:0] ramload
);
  import cpu_types_pkg::*;

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              act_q, act_d;
  logic [31:0]       p_addr_q, p_addr_d;
  logic              p_ren_q, p_ren_d;
  logic              p_wen_q, p_wen_d;

  logic              req, conflict, bad, same, mem_we;
  logic [CNT_W-1:0]  e;
  logic [ADDR_W-1:0] idx;
  ramstate_t         state;

  always_comb begin
    req      = ramREN ^ ramWEN;
    conflict = ramREN & ramWEN;
`ifdef LATENCY_RAM_ALIGN_CHECK_EN
    bad      = conflict | (req & (ramaddr[1:0] != 2'b00));
`else
    bad      = conflict;
`endif
    idx      = ramaddr[ADDR_W+1:2];
    // A wait count only carries over while the request is unchanged cycle to cycle.
    same     = act_q & (ramaddr == p_addr_q) & (ramREN == p_ren_q) & (ramWEN == p_wen_q);
    e        = same ? cnt_q : '0;

    state = FREE;
    if (bad)             state = ERROR;
    else if (!req)       state = FREE;
    else if (e == LAT_C) state = ACCESS;
    else                 state = BUSY;

    cnt_d    = '0;
    act_d    = 1'b0;
    p_addr_d = p_addr_q;
    p_ren_d  = p_ren_q;
    p_wen_d  = p_wen_q;
    if (state == BUSY) begin
      cnt_d    = e + CNT_W'(1);
      act_d    = 1'b1;
      p_addr_d = ramaddr;
      p_ren_d  = ramREN;
      p_wen_d  = ramWEN;
    end

    ramstate = state;
    ramload  = (state == ACCESS && ramREN) ? mem_q[idx] : 32'hBAD1BAD1;
    mem_we   = (state == ACCESS) && ramWEN;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q    <= '0;
      act_q    <= 1'b0;
      p_addr_q <= '0;
      p_ren_q  <= 1'b0;
      p_wen_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      p_addr_q <= p_addr_d;
      p_ren_q  <= p_ren_d;
      p_wen_q  <= p_wen_d;
    end
  end

  // Array is not reset; a reset held across the edge suppresses the commit.
  always_ff @(posedge CLK) begin
    if (mem_we && nRST) mem_q[idx] <= ramstore;
  end

endmodule
